// File: rtl/fsk_src_pkg.sv
// Shared encodings and LFSR constants for the FSK bit source.
package fsk_src_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS7   = 2'd0,
    MODE_PRBS15  = 2'd1,
    MODE_PATTERN = 2'd2,
    MODE_ALT     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int PRBS7_LEN    = 7;
  localparam int PRBS7_TAP_A  = 6;
  localparam int PRBS7_TAP_B  = 5;
  localparam int PRBS15_LEN   = 15;
  localparam int PRBS15_TAP_A = 14;
  localparam int PRBS15_TAP_B = 13;

  // Wide enough for any supported LFSR length; users slice the low bits.
  localparam int              SEED_W    = 32;
  localparam logic [SEED_W-1:0] PRBS_SEED = '1;

endpackage

// File: rtl/fsk_bit_source_if.sv
// Burst request / serial bit stream bundle between controller and FSK bit source.
interface fsk_bit_source_if #(
  parameter int DIV_W = 8,
  parameter int LEN_W = 16,
  parameter int PAT_W = 16
);
  logic             start;
  logic [1:0]       mode;
  logic [DIV_W-1:0] bit_div;
  logic [LEN_W-1:0] num_bits;
  logic [PAT_W-1:0] pattern;
  logic             tx_data;
  logic             bit_stb;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, bit_div, num_bits, pattern,
    input  tx_data, bit_stb, busy, done
  );

  modport slave (
    input  start, mode, bit_div, num_bits, pattern,
    output tx_data, bit_stb, busy, done
  );
endinterface

// File: rtl/fsk_lfsr.sv
// Fibonacci LFSR, shift-left with feedback into bit 0; fb is the bit produced by the next advance.
module fsk_lfsr
  import fsk_src_pkg::*;
#(
  parameter int LEN   = 7,
  parameter int TAP_A = 6,
  parameter int TAP_B = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic adv,
  output logic fb
);
  localparam logic [LEN-1:0] SEED = PRBS_SEED[LEN-1:0];

  logic [LEN-1:0] s_q;
  logic [LEN-1:0] base;

  // Seeding and the first advance can happen on the same edge.
  assign base = load ? SEED : s_q;
  assign fb   = base[TAP_A] ^ base[TAP_B];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       s_q <= SEED;
    else if (adv)  s_q <= {base[LEN-2:0], fb};
    else if (load) s_q <= SEED;
  end
endmodule

// File: rtl/fsk_bit_source.sv
// Burst bit generator for the FSK modulator: PRBS7/PRBS15/pattern/alternating sources,
// programmable bit period and burst length, all outputs registered.
module fsk_bit_source
  import fsk_src_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int LEN_W = 16,
  parameter int PAT_W = 16
) (
  input  logic             tx_clk,
  input  logic             reset,
  fsk_bit_source_if.slave  bus
);
  localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, cur_mode;
  logic [DIV_W-1:0] div_q, div_cnt;
  logic [LEN_W-1:0] bits_left;
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic             phase_q;
  logic             tx_q, stb_q, busy_q, done_q;
  logic             tx_d, stb_d, busy_d, done_d;
  logic             start_go, bit_end, last_bit, next_bit, lfsr_adv;
  logic             new_bit, p7_bit, p15_bit;

  assign start_go = (state_q == ST_IDLE) && bus.start;
  assign bit_end  = (state_q == ST_RUN) && (div_cnt == '0);
  assign last_bit = bit_end && (bits_left == '0);
  assign next_bit = bit_end && !last_bit;
  assign lfsr_adv = (start_go && (bus.num_bits != '0)) || next_bit;
  // Bit 0 leaves on the START edge, so it is chosen from the live inputs.
  assign cur_mode = start_go ? mode_e'(bus.mode) : mode_q;
  assign idx_nxt  = (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;

  fsk_lfsr #(.LEN(PRBS7_LEN), .TAP_A(PRBS7_TAP_A), .TAP_B(PRBS7_TAP_B)) u_prbs7 (
    .clk(tx_clk), .rst(reset), .load(start_go), .adv(lfsr_adv), .fb(p7_bit)
  );

  fsk_lfsr #(.LEN(PRBS15_LEN), .TAP_A(PRBS15_TAP_A), .TAP_B(PRBS15_TAP_B)) u_prbs15 (
    .clk(tx_clk), .rst(reset), .load(start_go), .adv(lfsr_adv), .fb(p15_bit)
  );

  always_comb begin
    new_bit = 1'b0;
    case (cur_mode)
      MODE_PRBS7:   new_bit = p7_bit;
      MODE_PRBS15:  new_bit = p15_bit;
      MODE_PATTERN: new_bit = start_go ? bus.pattern[PAT_W-1] : pat_q[idx_nxt];
      MODE_ALT:     new_bit = start_go ? 1'b0 : ~phase_q;
      default:      new_bit = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = (bus.num_bits != '0) ? ST_RUN : ST_FIN;
      ST_RUN:  if (last_bit)  state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic, computed one cycle ahead and registered below
  always_comb begin
    tx_d   = 1'b0;
    stb_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && (bus.num_bits != '0)) begin
          tx_d   = new_bit;
          stb_d  = 1'b1;
          busy_d = 1'b1;
        end else if (bus.start) begin
          done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_bit) begin
          done_d = 1'b1;
        end else if (next_bit) begin
          tx_d   = new_bit;
          stb_d  = 1'b1;
          busy_d = 1'b1;
        end else begin
          tx_d   = tx_q;
          busy_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      tx_q      <= 1'b0;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mode_q    <= MODE_PRBS7;
      div_q     <= '0;
      pat_q     <= '0;
      div_cnt   <= '0;
      bits_left <= '0;
      idx_q     <= '0;
      phase_q   <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      stb_q  <= stb_d;
      busy_q <= busy_d;
      done_q <= done_d;
      if (start_go) begin
        mode_q    <= mode_e'(bus.mode);
        div_q     <= bus.bit_div;
        pat_q     <= bus.pattern;
        div_cnt   <= bus.bit_div;
        bits_left <= bus.num_bits - 1'b1;
        idx_q     <= IDX_TOP;
        phase_q   <= 1'b0;
      end else if (state_q == ST_RUN) begin
        div_cnt <= bit_end ? div_q : div_cnt - 1'b1;
        if (next_bit) begin
          bits_left <= bits_left - 1'b1;
          idx_q     <= idx_nxt;
          phase_q   <= ~phase_q;
        end
      end
    end
  end

  assign bus.tx_data = tx_q;
  assign bus.bit_stb = stb_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: doc/fsk_bit_source.md
FSK_BIT_SOURCE -- requirements
Module: fsk_bit_source

Interface
REQ-001 Parameter DIV_W, default 8: width of the bit-period divisor.
REQ-002 Parameter LEN_W, default 16: width of the burst bit count.
REQ-003 Parameter PAT_W, default 16: width of the user pattern register.
REQ-004 TX_CLK  input  1  sole clock, all state on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 START  input  1  burst request, sampled only in IDLE.
REQ-007 MODE  input  2  data source: 0 PRBS7, 1 PRBS15, 2 repeating PATTERN, 3 alternating.
REQ-008 BIT_DIV  input  DIV_W  bit period minus one, in TX_CLK cycles.
REQ-009 NUM_BITS  input  LEN_W  bits per burst.
REQ-010 PATTERN  input  PAT_W  user pattern, sent MSB first.
REQ-011 TX_DATA  output  1  serial bit stream to the FSK modulator.
REQ-012 BIT_STB  output  1  one-cycle pulse on the first cycle of each bit.
REQ-013 BUSY  output  1  high while a burst is in progress.
REQ-014 DONE  output  1  one-cycle pulse at burst end.

Function
REQ-015 FSM states: IDLE, RUN, FIN; IDLE->RUN on START with NUM_BITS!=0; IDLE->FIN on START with NUM_BITS==0; RUN->FIN after last bit period; FIN->IDLE unconditionally next cycle.
REQ-016 At the START edge, MODE, BIT_DIV, NUM_BITS, PATTERN are latched; later input changes do not affect the running burst.
REQ-017 At the START edge, the PRBS register is reseeded to all ones, pattern index set to PAT_W-1, alternating phase set to 0.
REQ-018 Bit 0 is on TX_DATA, with BIT_STB=1 and BUSY=1, in the cycle immediately after the START edge (latency 1).
REQ-019 Each bit is held exactly BIT_DIV+1 cycles; BIT_DIV=0 gives one bit per cycle with BIT_STB continuously high.
REQ-020 Exactly NUM_BITS bits are sent; NUM_BITS is unsigned, all-ones value is legal.
REQ-021 PRBS7: state s[6:0], new bit = s[6]^s[5], shift left inserting new bit; TX_DATA = new bit; first seven bits from seed are 0,0,0,0,0,0,1.
REQ-022 PRBS15: state s[14:0], new bit = s[14]^s[13], same shift rule.
REQ-023 Pattern mode: TX_DATA = latched PATTERN[idx], idx decrements per bit and wraps from 0 to PAT_W-1.
REQ-024 Alternating mode: 0,1,0,1,... starting with 0.
REQ-025 PRBS/pattern/phase state advances only on bit boundaries, never within a bit period.
REQ-026 FIN cycle: DONE=1, BUSY=0, TX_DATA=0, BIT_STB=0.
REQ-027 IDLE: TX_DATA=0, BIT_STB=0, BUSY=0, DONE=0.
REQ-028 START while in RUN or FIN is ignored, no queuing; START held high re-triggers from IDLE, i.e. back-to-back bursts separated by FIN and one IDLE cycle.
REQ-029 All outputs are registered.

Reset
REQ-030 RESET asserted forces IDLE and TX_DATA=0, BIT_STB=0, BUSY=0, DONE=0 immediately, independent of TX_CLK.
REQ-031 RESET clears both counters, latched configuration and pattern index; PRBS register set to all ones.
REQ-032 RESET mid-burst aborts without a DONE pulse; first START after release behaves as from power-up.

Structure
REQ-033 Shared package fsk_src_pkg holds the MODE encodings, FSM state encodings, PRBS7/PRBS15 tap positions and the all-ones seed constant.
REQ-034 One sub-module fsk_lfsr (parametrised length and taps, with load-seed and advance inputs) is instantiated for the PRBS modes; divider, bit counter and FSM live in fsk_bit_source.

Verification
REQ-035 MODE=0, BIT_DIV=0, NUM_BITS=7, START one cycle -> TX_DATA 0,0,0,0,0,0,1 on the seven cycles after START, DONE one cycle later.
REQ-036 MODE=2, PATTERN=16'hA5F0, BIT_DIV=3, NUM_BITS=20 -> 1010010111110000 then 1010, each bit 4 cycles, 20 BIT_STB pulses, BUSY high 80 cycles.
REQ-037 MODE=3, NUM_BITS=0, START -> no BIT_STB, BUSY stays 0, DONE pulses in the cycle after START.
REQ-038 MODE=1, BIT_DIV=9, NUM_BITS=5, change MODE/BIT_DIV and pulse START during the burst -> burst unaffected, extra START ignored, 50-cycle burst.
REQ-039 RESET asserted between clock edges during bit 3 of a burst -> outputs zero immediately, no DONE; next START reproduces the burst from its first bit.
REQ-040 START held high, NUM_BITS=2, BIT_DIV=0 -> repeating bursts of 2 bits, DONE, one IDLE cycle, with identical bit content each burst.
